// File: rtl/pipe_mem_stage.sv
// MEM stage: data-memory access against an internal word RAM with a fixed
// number of wait states; stalls upstream and feeds bubbles to MEM/WB meanwhile.
module pipe_mem_stage #(
    parameter int DEPTH_LOG2  = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        mem_is_cond,
    output logic        mem_stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        wb_is_cond
);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             ram [DEPTH];
    logic [DEPTH_LOG2-1:0]   addr;
    logic [31:0]             rd_data;
    logic                    access;
    logic                    complete;
    logic                    ram_we;

    logic                    wwreg_q, wwreg_d;
    logic                    wm2reg_q, wm2reg_d;
    logic [31:0]             wmo_q, wmo_d;
    logic [31:0]             walu_q, walu_d;
    logic [4:0]              wrn_q, wrn_d;
    logic                    wcond_q, wcond_d;

    // Bits below the word and above the RAM range are dropped, so addresses alias.
    assign addr    = malu[DEPTH_LOG2+1:2];
    assign rd_data = ram[addr];
    assign access  = mwmem | mm2reg;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        if (WAIT_CYCLES != 0) begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        mem_stall = 1'b1;
                        cnt_d     = CNT_INIT;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        mem_stall = 1'b1;
                        cnt_d     = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign complete = ~mem_stall;
    // Gating with clrn keeps a store from landing while reset is held.
    assign ram_we   = complete & mwmem & clrn;

    always_comb begin
        if (complete) begin
            wwreg_d  = mwreg;
            wm2reg_d = mm2reg;
            walu_d   = malu;
            wrn_d    = mrn;
            wcond_d  = mem_is_cond;
            wmo_d    = mm2reg ? rd_data : 32'd0;
        end else begin
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
            walu_d   = walu_q;
            wrn_d    = 5'd0;
            wcond_d  = 1'b0;
            wmo_d    = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wmo_q    <= 32'd0;
            walu_q   <= 32'd0;
            wrn_q    <= 5'd0;
            wcond_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wmo_q    <= wmo_d;
            walu_q   <= walu_d;
            wrn_q    <= wrn_d;
            wcond_q  <= wcond_d;
        end
    end

    // Read data is sampled above before this write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr] <= mb;
        end
    end

    assign wwreg      = wwreg_q;
    assign wm2reg     = wm2reg_q;
    assign wmo        = wmo_q;
    assign walu       = walu_q;
    assign wrn        = wrn_q;
    assign wb_is_cond = wcond_q;
endmodule
